malu_resp_checker: RTL and testbench

//   Response-side end of the malu operand/result interface.
//   - Consumes (a, b, c) triples from the unit under test over a valid/ready handshake.
//   - Recomputes expected = (a & b) ^ MASK and compares it with the observed c.
//   - Counts passes and fails for a session of num_vec vectors.
//   - Captures the first mismatch of the session and raises done when the session ends.
//   - Sits beside the malu datapath as the self-checking receiver for bench and bring-up.

---
 rtl/malu_resp_checker.sv | 119 +++++++++++
 tb/tb_malu_resp_checker.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/malu_resp_checker.sv
// rtl/malu_resp_checker.sv - response-side checker for the malu operand/result interface
module malu_resp_checker #(
    parameter int               WIDTH = 4,
    parameter logic [WIDTH-1:0] MASK  = 4'b0110,
    parameter int               CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] num_vec,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic             err,
    output logic [CNT_W-1:0] first_fail_idx,
    output logic [WIDTH-1:0] first_fail_exp,
    output logic [WIDTH-1:0] first_fail_got
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] num_vec_q;
    logic [CNT_W-1:0] idx;
    logic [WIDTH-1:0] exp_val;
    logic             xfer;
    logic             last_xfer;

    // Expected result of the unit under test and handshake qualifiers for this cycle
    always_comb begin
        exp_val   = (a & b) ^ MASK;
        xfer      = in_valid && in_ready;
        last_xfer = (idx == (num_vec_q - CNT_W'(1)));
    end

    // Session FSM together with all result registers; flags are registered alongside state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            in_ready       <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            num_vec_q      <= '0;
            idx            <= '0;
            pass_cnt       <= '0;
            fail_cnt       <= '0;
            err            <= 1'b0;
            first_fail_idx <= '0;
            first_fail_exp <= '0;
            first_fail_got <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        num_vec_q      <= num_vec;
                        idx            <= '0;
                        pass_cnt       <= '0;
                        fail_cnt       <= '0;
                        err            <= 1'b0;
                        first_fail_idx <= '0;
                        first_fail_exp <= '0;
                        first_fail_got <= '0;
                        if (num_vec == '0) begin
                            state    <= DONE;
                            in_ready <= 1'b0;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                        end else begin
                            state    <= RUN;
                            in_ready <= 1'b1;
                            busy     <= 1'b1;
                            done     <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    // start is deliberately ignored here; num_vec stays as latched
                    if (xfer) begin
                        if (c == exp_val) begin
                            pass_cnt <= pass_cnt + CNT_W'(1);
                        end else begin
                            fail_cnt <= fail_cnt + CNT_W'(1);
                            err      <= 1'b1;
                            if (!err) begin
                                first_fail_idx <= idx;
                                first_fail_exp <= exp_val;
                                first_fail_got <= c;
                            end
                        end
                        idx <= idx + CNT_W'(1);
                        if (last_xfer) begin
                            state    <= DONE;
                            in_ready <= 1'b0;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b0;
                    busy     <= 1'b0;
                    done     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_malu_resp_checker.sv
// tb/tb_malu_resp_checker.sv - randomized self-checking bench for malu_resp_checker
module tb_malu_resp_checker;

    localparam int         WIDTH = 4;
    localparam int         CNT_W = 8;
    localparam logic [3:0] MASK  = 4'b0110;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [CNT_W-1:0] num_vec;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] c;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] pass_cnt;
    logic [CNT_W-1:0] fail_cnt;
    logic             err;
    logic [CNT_W-1:0] first_fail_idx;
    logic [WIDTH-1:0] first_fail_exp;
    logic [WIDTH-1:0] first_fail_got;

    int total = 0;
    int bad   = 0;

    int qa[$];
    int qb[$];
    int qc[$];

    malu_resp_checker #(.WIDTH(WIDTH), .MASK(MASK), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .num_vec        (num_vec),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .a              (a),
        .b              (b),
        .c              (c),
        .busy           (busy),
        .done           (done),
        .pass_cnt       (pass_cnt),
        .fail_cnt       (fail_cnt),
        .err            (err),
        .first_fail_idx (first_fail_idx),
        .first_fail_exp (first_fail_exp),
        .first_fail_got (first_fail_got)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        total++;
        if (got !== expv) begin
            bad++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"}, in_ready, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_pass"}, pass_cnt, 0);
        check({tag, "_fail"}, fail_cnt, 0);
        check({tag, "_fidx"}, first_fail_idx, 0);
        check({tag, "_fexp"}, first_fail_exp, 0);
        check({tag, "_fgot"}, first_fail_got, 0);
    endtask

    task automatic push_vec(input int av, input int bv, input int cv);
        qa.push_back(av);
        qb.push_back(bv);
        qc.push_back(cv);
    endtask

    task automatic load_random(input int n, input int err_pct);
        int av, bv, ev;
        qa.delete(); qb.delete(); qc.delete();
        for (int i = 0; i < n; i++) begin
            av = $urandom_range(0, 15);
            bv = $urandom_range(0, 15);
            ev = (av & bv) ^ 6;
            if ($urandom_range(0, 99) < err_pct)
                push_vec(av, bv, ev ^ $urandom_range(1, 15));
            else
                push_vec(av, bv, ev);
        end
    endtask

    // Runs one full session from the queued vectors and checks it against the model.
    task automatic run_session(input int n, input int gap_max, input bit start_mid);
        int m_pass, m_fail, f_idx, f_exp, f_got, ev, g, w;
        bit m_err;
        m_pass = 0; m_fail = 0; f_idx = 0; f_exp = 0; f_got = 0; m_err = 0;
        start   = 1'b1;
        num_vec = CNT_W'(n);
        tick();
        start   = 1'b0;
        num_vec = CNT_W'($urandom_range(0, 255));
        if (n == 0) begin
            check("zero_done", done, 1);
            check("zero_ready", in_ready, 0);
            check("zero_pass", pass_cnt, 0);
            check("zero_fail", fail_cnt, 0);
            check("zero_err", err, 0);
            return;
        end
        check("run_busy", busy, 1);
        check("run_ready", in_ready, 1);
        check("run_done", done, 0);
        for (int i = 0; i < n; i++) begin
            if (start_mid && i == n / 2) g = $urandom_range(1, gap_max + 1);
            else g = (gap_max > 0) ? $urandom_range(0, gap_max) : 0;
            for (int k = 0; k < g; k++) begin
                in_valid = 1'b0;
                a = 4'($urandom_range(0, 15));
                start = start_mid && (i == n / 2) && (k == 0);
                tick();
                start = 1'b0;
            end
            ev = (qa[i] & qb[i]) ^ 6;
            if (qc[i] == ev) begin
                m_pass++;
            end else begin
                if (!m_err) begin
                    f_idx = i; f_exp = ev; f_got = qc[i];
                end
                m_err = 1;
                m_fail++;
            end
            a = 4'(qa[i]); b = 4'(qb[i]); c = 4'(qc[i]);
            in_valid = 1'b1;
            w = 0;
            while (!in_ready && w < 20) begin
                tick();
                w++;
            end
            if (w == 20) check("ready_timeout", 0, 1);
            tick();
            in_valid = 1'b0;
            if (i < n - 1) begin
                check("mid_done", done, 0);
                check("mid_ready", in_ready, 1);
                check("mid_pass", pass_cnt, m_pass);
                check("mid_fail", fail_cnt, m_fail);
            end
        end
        check("end_done", done, 1);
        check("end_ready", in_ready, 0);
        check("end_busy", busy, 0);
        check("end_pass", pass_cnt, m_pass);
        check("end_fail", fail_cnt, m_fail);
        check("end_err", err, m_err);
        check("end_fidx", first_fail_idx, f_idx);
        check("end_fexp", first_fail_exp, f_exp);
        check("end_fgot", first_fail_got, f_got);
        // DONE must ignore further traffic and keep results stable
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            a = 4'($urandom_range(0, 15)); b = 4'($urandom_range(0, 15)); c = 4'($urandom_range(0, 15));
            tick();
        end
        in_valid = 1'b0;
        check("hold_done", done, 1);
        check("hold_ready", in_ready, 0);
        check("hold_pass", pass_cnt, m_pass);
        check("hold_fail", fail_cnt, m_fail);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; num_vec = '0; in_valid = 1'b0;
        a = '0; b = '0; c = '0;

        // reset held for two cycles
        tick();
        tick();
        check_all_zero("reset");
        rst_n = 1'b1;
        tick();
        check_all_zero("idle");

        // all-correct directed session, back to back
        qa.delete(); qb.delete(); qc.delete();
        push_vec(4'b0111, 4'b1111, 4'b0001);
        push_vec(4'b0100, 4'b1100, 4'b0010);
        push_vec(4'b0110, 4'b0100, 4'b0010);
        push_vec(4'b1001, 4'b0110, 4'b0110);
        run_session(4, 0, 1'b0);

        // gapped delivery with a start pulse mid-session
        run_session(4, 3, 1'b1);

        // third vector corrupted
        qc[2] = 4'b0011;
        run_session(4, 0, 1'b0);
        check("t3_fexp_lit", first_fail_exp, 4'b0010);
        check("t3_fgot_lit", first_fail_got, 4'b0011);
        check("t3_fidx_lit", first_fail_idx, 2);

        // empty session
        run_session(0, 0, 1'b0);

        // reset in the middle of a session
        start = 1'b1; num_vec = 8'd4;
        tick();
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            a = 4'b0111; b = 4'b1111; c = 4'b1111;
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        check("pre_rst_fail", fail_cnt, 2);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_all_zero("midrst");
        qa.delete(); qb.delete(); qc.delete();
        push_vec(4'b1001, 4'b0110, 4'b0110);
        run_session(1, 0, 1'b0);

        // randomized sessions
        for (int s = 0; s < 25; s++) begin
            int n;
            n = $urandom_range(0, 12);
            load_random(n, 30);
            run_session(n, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
